// File: rtl/relm_fifo_mc.sv
// relm_fifo_mc: multi-channel FIFO I/O bridge for the ReLM ring.
// Each of the NCH = 2**WCH channels is an independent FIFO of depth
// 2**WAD words. Every channel has one push port and one pop/command port.
// Commands are blocking POP, non-blocking POP, STATUS (occupancy) and FLUSH.
// Pop results are combinational in the command cycle.
// Optional feature: define RELM_FIFO_MC_WATERMARK_EN to get a registered
// per-channel "level >= WM" flag on wm_out. Otherwise wm_out is tied low.

// relm_dpmem: simple dual-port RAM, synchronous write, registered read
// (old data returned on a same-address read/write collision).
module relm_dpmem #(
   parameter int unsigned WAD = 4,
   parameter int unsigned WD  = 32
) (
   input  logic           clk,
   input  logic           we,
   input  logic [WAD-1:0] wa,
   input  logic [WD-1:0]  d,
   input  logic [WAD-1:0] ra,
   output logic [WD-1:0]  q
);

   logic [WD-1:0] mem [2**WAD];

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= d;
      end
      q <= mem[ra];
   end

endmodule

module relm_fifo_mc #(
   parameter int unsigned WAD = 4,
   parameter int unsigned WD  = 32,
   parameter int unsigned WCH = 1,
   parameter int unsigned WM  = 2**(WAD-1)
) (
   input  logic                          clk,
   input  logic                          rst_n_in,
   input  logic [(2**WCH)*(WD+1)-1:0]    push_d_in,
   output logic [(2**WCH)-1:0]           push_retry_out,
   input  logic [(2**WCH)*(WD+1)-1:0]    pop_d_in,
   output logic [(2**WCH)*(WD+1)-1:0]    pop_q_out,
   output logic [(2**WCH)-1:0]           wm_out
);

   localparam int unsigned NCH = 2**WCH;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic           push_v;
      logic [WD-1:0]  push_dat;
      logic           pop_v;
      logic [WD-1:0]  cmd;
      logic           cmd_unused;

      logic [WAD:0]   ra;
      logic [WAD:0]   wa;
      logic [WAD:0]   level;
      logic [WAD:0]   ra_nxt;
      logic [WAD:0]   wa_nxt;
      logic [WAD:0]   level_nxt;

      logic           empty;
      logic           full;
      logic           is_flush;
      logic           pop_con;
      logic           retry;
      logic           push_acc;
      logic [WD:0]    q;

      logic [WD-1:0]  mem_q;
      logic [WD-1:0]  head;
      logic           byp_hit;
      logic [WD-1:0]  byp_data;

      assign push_v   = push_d_in[c*(WD+1)+WD];
      assign push_dat = push_d_in[c*(WD+1) +: WD];
      assign pop_v    = pop_d_in[c*(WD+1)+WD];
      assign cmd      = pop_d_in[c*(WD+1) +: WD];

      // only cmd[WD-1] and cmd[0] carry meaning; the middle bits are ignored
      assign cmd_unused = ^cmd[WD-2:1];

      assign empty = (level == '0);
      assign full  = (wa[WAD-1:0] == ra[WAD-1:0]) && (wa[WAD] != ra[WAD]);

      // RAM reads old data on a collision, so a word written into the slot
      // being fetched as the next head is forwarded from a side register.
      assign head = byp_hit ? byp_data : mem_q;

      // command decode, push acceptance and combinational pop response
      always_comb begin
         is_flush = pop_v && !cmd[0] && cmd[WD-1];
         pop_con  = pop_v && cmd[0] && !empty;
         retry    = rst_n_in && ((full && !pop_con) || is_flush);
         push_acc = rst_n_in && push_v && !retry;

         q = '0;
         if (pop_v) begin
            if (cmd[0]) begin
               if (!empty) begin
                  q = {1'b0, head};
               end else if (!cmd[WD-1]) begin
                  q = {1'b1, {WD{1'b0}}};
               end
            end else begin
               q = {1'b0, {(WD-WAD-1){1'b0}}, level};
            end
         end
      end

      // next pointer and level values
      always_comb begin
         ra_nxt    = ra + {{WAD{1'b0}}, pop_con};
         wa_nxt    = wa + {{WAD{1'b0}}, push_acc};
         level_nxt = level + {{WAD{1'b0}}, push_acc} - {{WAD{1'b0}}, pop_con};
         if (is_flush) begin
            wa_nxt    = ra;
            level_nxt = '0;
         end
      end

      // pointer, level and head-forwarding state
      always_ff @(posedge clk or negedge rst_n_in) begin
         if (!rst_n_in) begin
            ra       <= '0;
            wa       <= '0;
            level    <= '0;
            byp_hit  <= 1'b0;
            byp_data <= '0;
         end else begin
            ra       <= ra_nxt;
            wa       <= wa_nxt;
            level    <= level_nxt;
            byp_hit  <= push_acc && (wa[WAD-1:0] == ra_nxt[WAD-1:0]);
            byp_data <= push_dat;
         end
      end

      relm_dpmem #(
         .WAD (WAD),
         .WD  (WD)
      ) u_mem (
         .clk (clk),
         .we  (push_acc),
         .wa  (wa[WAD-1:0]),
         .d   (push_dat),
         .ra  (ra_nxt[WAD-1:0]),
         .q   (mem_q)
      );

      assign push_retry_out[c]        = retry;
      assign pop_q_out[c*(WD+1) +: WD+1] = q;

`ifdef RELM_FIFO_MC_WATERMARK_EN
      localparam logic [WAD:0] WM_LVL = (WAD+1)'(WM);
      logic wm_r;

      // watermark flag follows the level that this edge commits
      always_ff @(posedge clk or negedge rst_n_in) begin
         if (!rst_n_in) begin
            wm_r <= 1'b0;
         end else begin
            wm_r <= (level_nxt >= WM_LVL);
         end
      end

      assign wm_out[c] = wm_r;
`else
      assign wm_out[c] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_relm_fifo_mc.sv
// tb_relm_fifo_mc: directed plus randomized bench for relm_fifo_mc
// (WAD=2, WD=32, WCH=1, WM=2). Expected values come from a queue-per-channel
// reference model. Honours RELM_FIFO_MC_WATERMARK_EN for wm_out expectations.
module tb_relm_fifo_mc;

   localparam int unsigned WAD   = 2;
   localparam int unsigned WD    = 32;
   localparam int unsigned WCH   = 1;
   localparam int unsigned WM    = 2;
   localparam int unsigned NCH   = 2;
   localparam int unsigned DEPTH = 4;

   localparam logic [31:0] C_POP   = 32'h0000_0001;
   localparam logic [31:0] C_NBPOP = 32'h8000_0001;
   localparam logic [31:0] C_STAT  = 32'h0000_0000;
   localparam logic [31:0] C_FLUSH = 32'h8000_0000;

   logic              clk = 1'b0;
   logic              rst_n_in;
   logic [2*33-1:0]   push_d_in;
   logic [1:0]        push_retry_out;
   logic [2*33-1:0]   pop_d_in;
   logic [2*33-1:0]   pop_q_out;
   logic [1:0]        wm_out;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [31:0] mq [2][$];

   logic        p_v [2];
   logic [31:0] p_d [2];
   logic        c_v [2];
   logic [31:0] c_d [2];

   relm_fifo_mc #(
      .WAD (WAD),
      .WD  (WD),
      .WCH (WCH),
      .WM  (WM)
   ) dut (
      .clk            (clk),
      .rst_n_in       (rst_n_in),
      .push_d_in      (push_d_in),
      .push_retry_out (push_retry_out),
      .pop_d_in       (pop_d_in),
      .pop_q_out      (pop_q_out),
      .wm_out         (wm_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input int ch, input logic [32:0] obs, input logic [32:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s ch%0d: observed %h expected %h", tag, ch, obs, exp_v);
      end
   endtask

   function automatic logic exp_wm(input int unsigned lvl);
`ifdef RELM_FIFO_MC_WATERMARK_EN
      return (lvl >= WM);
`else
      return 1'b0;
`endif
   endfunction

   task automatic clear_stim();
      for (int c = 0; c < NCH; c++) begin
         p_v[c] = 1'b0;
         p_d[c] = '0;
         c_v[c] = 1'b0;
         c_d[c] = '0;
      end
   endtask

   task automatic apply_inputs();
      for (int c = 0; c < NCH; c++) begin
         push_d_in[c*33 +: 33] = {p_v[c], p_d[c]};
         pop_d_in[c*33 +: 33]  = {c_v[c], c_d[c]};
      end
   endtask

   task automatic check_idle_reset(input string tag);
      for (int c = 0; c < NCH; c++) begin
         check({tag, "_retry"}, c, {32'h0, push_retry_out[c]}, 33'h0);
         check({tag, "_wm"}, c, {32'h0, wm_out[c]}, 33'h0);
         check({tag, "_popq"}, c, pop_q_out[c*33 +: 33], 33'h0);
      end
   endtask

   // one clock cycle: drive, check combinational outputs, clock, update model
   task automatic run_cycle();
      logic [32:0] exp_q [2];
      logic        exp_retry [2];
      logic        consume [2];
      logic        accept [2];
      logic        flush [2];
      @(negedge clk);
      apply_inputs();
      #1;
      for (int c = 0; c < NCH; c++) begin
         int unsigned lvl;
         lvl        = mq[c].size();
         consume[c] = 1'b0;
         flush[c]   = 1'b0;
         exp_q[c]   = '0;
         if (c_v[c]) begin
            if (c_d[c][0]) begin
               if (lvl != 0) begin
                  exp_q[c]   = {1'b0, mq[c][0]};
                  consume[c] = 1'b1;
               end else if (!c_d[c][31]) begin
                  exp_q[c] = {1'b1, 32'h0};
               end
            end else begin
               exp_q[c] = {1'b0, 32'(lvl)};
               flush[c] = c_d[c][31];
            end
         end
         exp_retry[c] = ((lvl == DEPTH) && !consume[c]) || flush[c];
         accept[c]    = p_v[c] && !exp_retry[c];
         check("pop_q", c, pop_q_out[c*33 +: 33], exp_q[c]);
         check("push_retry", c, {32'h0, push_retry_out[c]}, {32'h0, exp_retry[c]});
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (consume[c]) void'(mq[c].pop_front());
         if (flush[c]) mq[c].delete();
         else if (accept[c]) mq[c].push_back(p_d[c]);
         check("wm", c, {32'h0, wm_out[c]}, {32'h0, exp_wm(mq[c].size())});
      end
   endtask

   task automatic do_push(input int ch, input logic [31:0] d);
      clear_stim();
      p_v[ch] = 1'b1;
      p_d[ch] = d;
      run_cycle();
   endtask

   task automatic do_cmd(input int ch, input logic [31:0] cm);
      clear_stim();
      c_v[ch] = 1'b1;
      c_d[ch] = cm;
      run_cycle();
   endtask

   initial begin
      rst_n_in = 1'b0;
      clear_stim();
      p_v[0] = 1'b1; p_d[0] = 32'hDEAD_0000;
      p_v[1] = 1'b1; p_d[1] = 32'hDEAD_0001;
      apply_inputs();
      repeat (2) @(negedge clk);
      #1;
      check_idle_reset("reset");
      @(negedge clk);
      rst_n_in = 1'b1;
      clear_stim();
      apply_inputs();

      // ordered data through ch0, then pop on empty
      do_push(0, 32'h11);
      do_push(0, 32'h22);
      do_push(0, 32'h33);
      do_cmd(0, C_POP);
      do_cmd(0, C_POP);
      do_cmd(0, C_POP);
      do_cmd(0, C_POP);

      // fill ch1 past depth, status of both channels
      for (int i = 0; i < 5; i++) do_push(1, 32'h100 + i);
      do_cmd(1, C_STAT);
      do_cmd(0, C_STAT);

      // ch0 full: push and pop together
      for (int i = 0; i < 4; i++) do_push(0, 32'hA0 + i);
      clear_stim();
      p_v[0] = 1'b1; p_d[0] = 32'hAA;
      c_v[0] = 1'b1; c_d[0] = C_POP;
      run_cycle();
      do_cmd(0, C_STAT);

      // ch0 at level 3: flush with a push
      do_cmd(0, C_POP);
      clear_stim();
      p_v[0] = 1'b1; p_d[0] = 32'h55;
      c_v[0] = 1'b1; c_d[0] = C_FLUSH;
      run_cycle();
      do_cmd(0, C_STAT);
      do_cmd(0, C_NBPOP);

      // watermark crossing and push/pop on an empty channel
      do_push(0, 32'h61);
      do_push(0, 32'h62);
      do_cmd(0, C_POP);
      do_cmd(0, C_POP);
      clear_stim();
      p_v[0] = 1'b1; p_d[0] = 32'h63;
      c_v[0] = 1'b1; c_d[0] = C_POP;
      run_cycle();
      do_cmd(0, C_POP);

      // mid-stream reset with ch1 at level 3
      do_cmd(1, C_POP);
      do_push(0, 32'h70);
      do_push(0, 32'h71);
      @(negedge clk);
      clear_stim();
      p_v[1] = 1'b1; p_d[1] = 32'hBAD1;
      apply_inputs();
      rst_n_in = 1'b0;
      #1;
      check_idle_reset("midrst");
      for (int c = 0; c < NCH; c++) mq[c].delete();
      @(posedge clk);
      #1;
      check_idle_reset("midrst_edge");
      @(negedge clk);
      rst_n_in = 1'b1;
      clear_stim();
      apply_inputs();
      do_cmd(1, C_STAT);
      do_push(1, 32'h77);
      do_cmd(1, C_POP);

      // randomized traffic on both channels
      for (int n = 0; n < 400; n++) begin
         clear_stim();
         for (int c = 0; c < NCH; c++) begin
            int unsigned sel;
            p_v[c] = ($urandom_range(0, 9) < 6);
            p_d[c] = $urandom;
            c_v[c] = ($urandom_range(0, 9) < 6);
            c_d[c] = $urandom;
            sel    = $urandom_range(0, 19);
            if (sel < 8)       begin c_d[c][0] = 1'b1; c_d[c][31] = 1'b0; end
            else if (sel < 13) begin c_d[c][0] = 1'b1; c_d[c][31] = 1'b1; end
            else if (sel < 18) begin c_d[c][0] = 1'b0; c_d[c][31] = 1'b0; end
            else               begin c_d[c][0] = 1'b0; c_d[c][31] = 1'b1; end
         end
         run_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
